idli_vop_seq_m: RTL and testbench

- Stack-transfer sequencer directly downstream of the virtual-op splitter.
- Receives the captured 8-bit register mask of a PUSH/POP and produces one control slot per 4-cycle nibble period:
  - one SP-adjust slot carrying POPCNT(mask) as a nibble-serial immediate;
  - one transfer slot per set register.
- The splitter uses the register index and immediate to build the SQI load/store ops.

---
 rtl/idli_vop_seq_m_if.sv | 31 +++
 rtl/idli_vop_seq_m.sv | 128 ++++++++++++
 tb/tb_idli_vop_seq_m.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/idli_vop_seq_m_if.sv
// Stack-transfer sequencer bus: nibble counter, start/advance/kill controls,
// and the per-slot control outputs consumed by the virtual-op splitter.
interface idli_vop_seq_m_if;
  logic [1:0] i_vop_ctr;
  logic       i_seq_start;
  logic       i_seq_push;
  logic [7:0] i_seq_mask;
  logic       i_seq_adv;
  logic       i_seq_kill;
  logic       o_seq_busy;
  logic       o_seq_adj;
  logic       o_seq_push;
  logic [3:0] o_seq_imm;
  logic [2:0] o_seq_reg;
  logic       o_seq_reg_vld;
  logic       o_seq_last;
  logic       o_seq_done;
  logic       o_seq_err;

  modport master (
    output i_vop_ctr, i_seq_start, i_seq_push, i_seq_mask, i_seq_adv, i_seq_kill,
    input  o_seq_busy, o_seq_adj, o_seq_push, o_seq_imm, o_seq_reg,
           o_seq_reg_vld, o_seq_last, o_seq_done, o_seq_err
  );

  modport slave (
    input  i_vop_ctr, i_seq_start, i_seq_push, i_seq_mask, i_seq_adv, i_seq_kill,
    output o_seq_busy, o_seq_adj, o_seq_push, o_seq_imm, o_seq_reg,
           o_seq_reg_vld, o_seq_last, o_seq_done, o_seq_err
  );
endinterface

// File: rtl/idli_vop_seq_m.sv
// PUSH/POP stack-transfer sequencer. One SP-adjust slot (popcount immediate)
// followed by one transfer slot per set mask bit; slots are 4 nibble cycles.
// Optional macro IDLI_VOP_SEQ_REVERSE_EN: PUSH transfers highest register first.
module idli_vop_seq_m #(
  parameter int SLOT_CYCLES = 4
) (
  input  logic          i_vop_gck,
  input  logic          i_vop_rst_n,
  idli_vop_seq_m_if.slave bus
);

  if (SLOT_CYCLES != 4) begin : g_bad_slot
    $error("idli_vop_seq_m: SLOT_CYCLES must be 4");
  end

  typedef enum logic [1:0] {IDLE, ADJ, XFER} state_t;

  state_t     state, state_nxt;
  logic [7:0] mask_q;
  logic       push_q;
  logic       kill_pend;
  logic       done_q;
  logic       err_q;
  logic       first_q;   // registered "this cycle is ctr 0" to keep imm input-free

  logic       slot_end;
  logic       kill_any;
  logic [3:0] pc;
  logic [2:0] sel;
  logic       last;
  logic       complete;
  logic       start_ok;
  logic       busy;

  function automatic logic [3:0] popcnt8(logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, m[i]};
    return c;
  endfunction

  assign slot_end = (bus.i_vop_ctr == 2'd3);
  assign kill_any = kill_pend | bus.i_seq_kill;
  assign pc       = popcnt8(mask_q);
  assign last     = (pc == 4'd1);
  assign busy     = (state != IDLE);
  // Final transfer accepted this slot without an abort.
  assign complete = (state == XFER) && slot_end && !kill_any && bus.i_seq_adv && last;
  // A start is taken from IDLE or in the cycle the previous op completes.
  assign start_ok = slot_end && bus.i_seq_start && ((state == IDLE) || complete);

  // Pick the register for the current transfer slot.
  always_comb begin
    sel = 3'd0;
`ifdef IDLI_VOP_SEQ_REVERSE_EN
    if (push_q) begin
      for (int i = 0; i < 8; i++) if (mask_q[i]) sel = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--) if (mask_q[i]) sel = 3'(i);
    end
`else
    for (int i = 7; i >= 0; i--) if (mask_q[i]) sel = 3'(i);
`endif
  end

  // State register.
  always_ff @(posedge i_vop_gck or negedge i_vop_rst_n) begin
    if (!i_vop_rst_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state: moves only on the last nibble cycle of a slot.
  always_comb begin
    state_nxt = state;
    if (slot_end) begin
      case (state)
        IDLE: if (bus.i_seq_start && (bus.i_seq_mask != 8'd0)) state_nxt = ADJ;
        ADJ:  state_nxt = kill_any ? IDLE : XFER;
        XFER: begin
          if (kill_any)                        state_nxt = IDLE;
          else if (bus.i_seq_adv && last)      state_nxt = (start_ok && (bus.i_seq_mask != 8'd0)) ? ADJ : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Mask/direction, kill pending, done pulse, sticky error, nibble phase.
  always_ff @(posedge i_vop_gck or negedge i_vop_rst_n) begin
    if (!i_vop_rst_n) begin
      mask_q    <= 8'd0;
      push_q    <= 1'b0;
      kill_pend <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      first_q <= slot_end;
      if (start_ok) begin
        mask_q <= bus.i_seq_mask;
        push_q <= bus.i_seq_push;
      end else if (busy && slot_end && kill_any) begin
        mask_q <= 8'd0;
      end else if ((state == XFER) && slot_end && bus.i_seq_adv) begin
        mask_q <= mask_q & ~(8'd1 << sel);
      end
      if (slot_end)                    kill_pend <= 1'b0;
      else if (busy && bus.i_seq_kill) kill_pend <= 1'b1;
      done_q <= (start_ok && (bus.i_seq_mask == 8'd0)) || complete ||
                (busy && slot_end && kill_any);
      if (slot_end && bus.i_seq_start && busy && !complete) err_q <= 1'b1;
    end
  end

  // Outputs decoded from state and flops only.
  always_comb begin
    bus.o_seq_busy    = busy;
    bus.o_seq_adj     = (state == ADJ);
    bus.o_seq_push    = push_q;
    bus.o_seq_imm     = ((state == ADJ) && first_q) ? pc : 4'd0;
    bus.o_seq_reg     = (state == XFER) ? sel : 3'd0;
    bus.o_seq_reg_vld = (state == XFER);
    bus.o_seq_last    = (state == XFER) && last;
    bus.o_seq_done    = done_q;
    bus.o_seq_err     = err_q;
  end

endmodule

// File: tb/tb_idli_vop_seq_m.sv
// Directed bench for idli_vop_seq_m: slot-by-slot checks of adjust/transfer
// sequencing, hold, kill, zero mask, back-to-back start, error and reset.
module tb_idli_vop_seq_m;
  logic gck;
  logic rst_n;
  int   checks;
  int   failures;

  idli_vop_seq_m_if bus();

  idli_vop_seq_m #(.SLOT_CYCLES(4)) dut (
    .i_vop_gck   (gck),
    .i_vop_rst_n (rst_n),
    .bus         (bus)
  );

  initial begin
    gck = 1'b0;
    forever #5 gck = ~gck;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; the bench owns the free-running nibble counter.
  task automatic tick();
    @(posedge gck);
    #1;
    bus.i_vop_ctr = bus.i_vop_ctr + 2'd1;
  endtask

  task automatic to_ctr3();
    for (int k = 0; k < 4 && bus.i_vop_ctr != 2'd3; k++) tick();
  endtask

  task automatic start_op(input logic p, input logic [7:0] m);
    to_ctr3();
    bus.i_seq_start = 1'b1;
    bus.i_seq_push  = p;
    bus.i_seq_mask  = m;
    tick();
    bus.i_seq_start = 1'b0;
  endtask

  // Check one whole busy slot starting at ctr 0; adv held for the slot.
  task automatic slot(input string tag, input logic adj, input int imm0,
                      input int rg, input logic vld, input logic lst, input logic adv);
    bus.i_seq_adv = adv;
    for (int c = 0; c < 4; c++) begin
      chk({tag, "_busy"}, 32'(bus.o_seq_busy), 1);
      chk({tag, "_adj"},  32'(bus.o_seq_adj), 32'(adj));
      chk({tag, "_imm"},  32'(bus.o_seq_imm), (c == 0) ? imm0 : 0);
      chk({tag, "_vld"},  32'(bus.o_seq_reg_vld), 32'(vld));
      if (vld) chk({tag, "_reg"}, 32'(bus.o_seq_reg), rg);
      chk({tag, "_last"}, 32'(bus.o_seq_last), 32'(lst));
      tick();
    end
    bus.i_seq_adv = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.o_seq_busy), 0);
    chk({tag, "_adj"},  32'(bus.o_seq_adj), 0);
    chk({tag, "_push"}, 32'(bus.o_seq_push), 0);
    chk({tag, "_imm"},  32'(bus.o_seq_imm), 0);
    chk({tag, "_reg"},  32'(bus.o_seq_reg), 0);
    chk({tag, "_vld"},  32'(bus.o_seq_reg_vld), 0);
    chk({tag, "_last"}, 32'(bus.o_seq_last), 0);
    chk({tag, "_done"}, 32'(bus.o_seq_done), 0);
    chk({tag, "_err"},  32'(bus.o_seq_err), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.i_vop_ctr   = 2'd0;
    bus.i_seq_start = 1'b0;
    bus.i_seq_push  = 1'b0;
    bus.i_seq_mask  = 8'd0;
    bus.i_seq_adv   = 1'b0;
    bus.i_seq_kill  = 1'b0;
    tick();
    tick();
    chk_zero("rst");
    rst_n = 1'b1;
    tick();

    // POP 0x05: adjust imm 2, then reg 0, then reg 2 (last)
    start_op(1'b0, 8'h05);
    slot("pop05_adj", 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
    slot("pop05_x0",  1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    slot("pop05_x1",  1'b0, 0, 2, 1'b1, 1'b1, 1'b1);
    chk("pop05_done", 32'(bus.o_seq_done), 1);
    chk("pop05_idle", 32'(bus.o_seq_busy), 0);
    tick();
    chk("pop05_done_clr", 32'(bus.o_seq_done), 0);

    // Zero mask: no adjust slot, single done pulse
    start_op(1'b0, 8'h00);
    chk("zero_done", 32'(bus.o_seq_done), 1);
    chk("zero_busy", 32'(bus.o_seq_busy), 0);
    chk("zero_adj",  32'(bus.o_seq_adj), 0);
    tick();
    chk("zero_done_clr", 32'(bus.o_seq_done), 0);
    chk("zero_busy2",    32'(bus.o_seq_busy), 0);

    // PUSH 0xFF: adjust imm 8, eight transfers
    start_op(1'b1, 8'hFF);
    chk("push_dir", 32'(bus.o_seq_push), 1);
    slot("pushff_adj", 1'b1, 8, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
`ifdef IDLI_VOP_SEQ_REVERSE_EN
      slot("pushff_x", 1'b0, 0, 7 - i, 1'b1, (i == 7), 1'b1);
`else
      slot("pushff_x", 1'b0, 0, i, 1'b1, (i == 7), 1'b1);
`endif
    end
    chk("pushff_done", 32'(bus.o_seq_done), 1);
    chk("pushff_idle", 32'(bus.o_seq_busy), 0);

    // POP 0x12 with a held first transfer
    start_op(1'b0, 8'h12);
    chk("pop_dir", 32'(bus.o_seq_push), 0);
    slot("pop12_adj",  1'b1, 2, 0, 1'b0, 1'b0, 1'b1);
    slot("pop12_hold", 1'b0, 0, 1, 1'b1, 1'b0, 1'b0);
    slot("pop12_x1",   1'b0, 0, 1, 1'b1, 1'b0, 1'b1);
    slot("pop12_x4",   1'b0, 0, 4, 1'b1, 1'b1, 1'b1);
    chk("pop12_done", 32'(bus.o_seq_done), 1);

    // Kill at ctr 1 of the first transfer of 0x0F
    start_op(1'b0, 8'h0F);
    slot("kill_adj", 1'b1, 4, 0, 1'b0, 1'b0, 1'b0);
    chk("kill_vld0", 32'(bus.o_seq_reg_vld), 1);
    chk("kill_reg0", 32'(bus.o_seq_reg), 0);
    tick();
    bus.i_seq_kill = 1'b1;
    tick();
    bus.i_seq_kill = 1'b0;
    bus.i_seq_adv  = 1'b1;
    tick();
    tick();
    bus.i_seq_adv = 1'b0;
    chk("kill_busy", 32'(bus.o_seq_busy), 0);
    chk("kill_done", 32'(bus.o_seq_done), 1);
    chk("kill_vld",  32'(bus.o_seq_reg_vld), 0);
    tick();
    chk("kill_vld2",  32'(bus.o_seq_reg_vld), 0);
    chk("kill_done2", 32'(bus.o_seq_done), 0);

    // Start accepted in the completing cycle of the previous op
    start_op(1'b0, 8'h01);
    slot("b2b_adj", 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    bus.i_seq_start = 1'b1;
    bus.i_seq_mask  = 8'h04;
    slot("b2b_x0", 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    bus.i_seq_start = 1'b0;
    chk("b2b_done", 32'(bus.o_seq_done), 1);
    chk("b2b_adj2", 32'(bus.o_seq_adj), 1);
    slot("b2b_adj2s", 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    slot("b2b_x2",    1'b0, 0, 2, 1'b1, 1'b1, 1'b1);
    chk("b2b_done2", 32'(bus.o_seq_done), 1);
    chk("b2b_noerr", 32'(bus.o_seq_err), 0);

    // Start while busy sets sticky error; then reset mid-transfer
    start_op(1'b0, 8'h03);
    slot("err_adj", 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
    to_ctr3();
    bus.i_seq_start = 1'b1;
    bus.i_seq_mask  = 8'hFF;
    tick();
    bus.i_seq_start = 1'b0;
    chk("err_set",  32'(bus.o_seq_err), 1);
    chk("err_busy", 32'(bus.o_seq_busy), 1);
    chk("err_reg",  32'(bus.o_seq_reg), 0);
    chk("err_adj0", 32'(bus.o_seq_adj), 0);
    tick();
    tick();
    tick();
    tick();
    chk("err_sticky", 32'(bus.o_seq_err), 1);
    chk("err_vld",    32'(bus.o_seq_reg_vld), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    chk_zero("midrst2");
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
